// File: rtl/rv32i_types.sv
// Shared RV32I types: jump-unit opcodes, BHT counter encodings and the BTB entry layout.
package rv32i_types;

  // opc[3] clear marks a conditional branch
  typedef enum logic [3:0] {
    OpcBeq  = 4'b0000,
    OpcBne  = 4'b0001,
    OpcBlt  = 4'b0100,
    OpcBge  = 4'b0101,
    OpcBltu = 4'b0110,
    OpcBgeu = 4'b0111,
    OpcJal  = 4'b1000,
    OpcJalr = 4'b1001
  } jmp_opc_e;

  typedef enum logic [1:0] {
    CntSnt = 2'd0,
    CntWnt = 2'd1,
    CntWt  = 2'd2,
    CntSt  = 2'd3
  } bht_cnt_e;

  // Tag is held right-aligned at full width; unused upper bits stay zero.
  typedef struct packed {
    logic        valid;
    logic        is_cond;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  function automatic logic is_cond_opc(logic [3:0] opc);
    return ~opc[3];
  endfunction

endpackage

// File: rtl/bpu_if.sv
// Fetch-lookup and execute-update signal bundle between the core and the BPU.
interface bpu_if;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        predict_valid;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        execute;
  logic [3:0]  opc;
  logic        update;
  logic [31:0] execute_pc;
  logic [31:0] execute_target;
  logic        execute_taken;

  modport master (
    output fetch_req, fetch_pc, execute, opc, update, execute_pc, execute_target,
           execute_taken,
    input  predict_valid, predict_taken, predict_target
  );

  modport slave (
    input  fetch_req, fetch_pc, execute, opc, update, execute_pc, execute_target,
           execute_taken,
    output predict_valid, predict_taken, predict_target
  );
endinterface

// File: rtl/bpu_sat_cnt.sv
// 2-bit saturating direction counter next-state logic.
module bpu_sat_cnt
  import rv32i_types::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CntSt) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != CntSnt) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/bpu.sv
// Branch predictor: direct-mapped BTB plus 2-bit BHT, one-cycle registered lookup.
// Define BPU_GSHARE_EN to XOR a global history register into the BHT index.
module bpu
  import rv32i_types::*;
#(
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned BTB_DEPTH = 16,
  parameter int unsigned GHR_W     = 6
) (
  input logic   clk,
  input logic   rst,
  bpu_if.slave  bus
);

  localparam int unsigned BtbIdxW = $clog2(BTB_DEPTH);
  localparam int unsigned BhtIdxW = $clog2(BHT_DEPTH);

  if (GHR_W == 0 || GHR_W > BhtIdxW) begin : gen_bad_ghr_w
    $error("GHR_W must be in 1..log2(BHT_DEPTH)");
  end

  btb_entry_t btb_q [BTB_DEPTH];
  logic [1:0] bht_q [BHT_DEPTH];

  logic [BtbIdxW-1:0] f_btb_idx, x_btb_idx;
  logic [BhtIdxW-1:0] f_bht_idx, x_bht_idx;
  logic [31:0]        f_tag, x_tag;
  logic               bht_upd;
  logic [1:0]         bht_nxt;
  btb_entry_t         rd_entry, wr_entry;

  logic        pv_d, pv_q, pt_d, pt_q;
  logic [31:0] ptg_d, ptg_q;

  assign f_btb_idx = bus.fetch_pc[BtbIdxW+1:2];
  assign x_btb_idx = bus.execute_pc[BtbIdxW+1:2];
  assign f_tag     = bus.fetch_pc >> (BtbIdxW + 2);
  assign x_tag     = bus.execute_pc >> (BtbIdxW + 2);
  assign bht_upd   = bus.execute && is_cond_opc(bus.opc);

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // Both lookup and update hash with the history as it stands this cycle.
  assign f_bht_idx = bus.fetch_pc[BhtIdxW+1:2] ^ BhtIdxW'(ghr_q);
  assign x_bht_idx = bus.execute_pc[BhtIdxW+1:2] ^ BhtIdxW'(ghr_q);

  always_comb begin
    ghr_d = ghr_q;
    if (bht_upd) ghr_d = (ghr_q << 1) | GHR_W'(bus.execute_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  assign f_bht_idx = bus.fetch_pc[BhtIdxW+1:2];
  assign x_bht_idx = bus.execute_pc[BhtIdxW+1:2];
`endif

  bpu_sat_cnt u_sat_cnt (
    .cnt_i   (bht_q[x_bht_idx]),
    .taken_i (bus.execute_taken),
    .cnt_o   (bht_nxt)
  );

  // Reads use the registered tables, so a same-cycle update is seen only by later lookups.
  always_comb begin
    rd_entry = btb_q[f_btb_idx];
    pv_d     = 1'b0;
    pt_d     = 1'b0;
    ptg_d    = '0;
    if (bus.fetch_req && rd_entry.valid && rd_entry.tag == f_tag) begin
      pv_d  = 1'b1;
      ptg_d = rd_entry.target;
      pt_d  = rd_entry.is_cond ? bht_q[f_bht_idx][1] : 1'b1;
    end
  end

  always_comb begin
    wr_entry.valid   = 1'b1;
    wr_entry.is_cond = is_cond_opc(bus.opc);
    wr_entry.tag     = x_tag;
    wr_entry.target  = bus.execute_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_q <= '{default: '0};
      bht_q <= '{default: CntWnt};
      pv_q  <= 1'b0;
      pt_q  <= 1'b0;
      ptg_q <= '0;
    end else begin
      pv_q  <= pv_d;
      pt_q  <= pt_d;
      ptg_q <= ptg_d;
      if (bus.update) btb_q[x_btb_idx] <= wr_entry;
      if (bht_upd)    bht_q[x_bht_idx] <= bht_nxt;
    end
  end

  assign bus.predict_valid  = pv_q;
  assign bus.predict_taken  = pt_q;
  assign bus.predict_target = ptg_q;

endmodule

// File: tb/tb_bpu.sv
// Directed bench for bpu: lookup/update, counter saturation, aliasing, bypass order, reset.
module tb_bpu;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  bpu_if bus_if ();

  bpu #(
    .BHT_DEPTH (64),
    .BTB_DEPTH (16),
    .GHR_W     (6)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.fetch_req      = 1'b0;
    bus_if.fetch_pc       = '0;
    bus_if.execute        = 1'b0;
    bus_if.opc            = OpcBeq;
    bus_if.update         = 1'b0;
    bus_if.execute_pc     = '0;
    bus_if.execute_target = '0;
    bus_if.execute_taken  = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    idle();
    bus_if.fetch_req = 1'b1;
    bus_if.fetch_pc  = pc;
    tick();
    idle();
  endtask

  task automatic exec(input logic [31:0] pc, input logic [3:0] opc, input logic upd,
                      input logic ex, input logic taken, input logic [31:0] tgt);
    idle();
    bus_if.execute_pc     = pc;
    bus_if.opc            = opc;
    bus_if.update         = upd;
    bus_if.execute        = ex;
    bus_if.execute_taken  = taken;
    bus_if.execute_target = tgt;
    tick();
    idle();
  endtask

  task automatic check_pred(input string tag, input logic v, input logic t,
                            input logic [31:0] tgt);
    check_eq({tag, "_valid"}, 32'(bus_if.predict_valid), 32'(v));
    if (v) begin
      check_eq({tag, "_taken"}, 32'(bus_if.predict_taken), 32'(t));
      check_eq({tag, "_target"}, bus_if.predict_target, tgt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  miss;
    int  late_miss;
    logic pred;
    logic actual;

    idle();
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", 32'(bus_if.predict_valid), 32'd0);
    check_eq("rst_taken", 32'(bus_if.predict_taken), 32'd0);
    check_eq("rst_target", bus_if.predict_target, 32'd0);
    rst = 1'b0;

    lookup(32'h0000_1000);
    check_pred("cold", 1'b0, 1'b0, 32'h0);

    exec(32'h1000, OpcJal, 1'b1, 1'b1, 1'b1, 32'h2000);
    lookup(32'h1000);
    check_pred("jal", 1'b1, 1'b1, 32'h2000);

    // Idle fetch on a hitting PC must still report no prediction
    bus_if.fetch_pc = 32'h1000;
    tick();
    check_eq("noreq_valid", 32'(bus_if.predict_valid), 32'd0);

    // Conditional branch at 0x1040: counter 1 -> 2 -> 3 -> 3
    exec(32'h1040, OpcBeq, 1'b1, 1'b1, 1'b1, 32'h1100);
    exec(32'h1040, OpcBeq, 1'b0, 1'b1, 1'b1, 32'h0);
    exec(32'h1040, OpcBeq, 1'b0, 1'b1, 1'b1, 32'h0);
    lookup(32'h1040);
    check_pred("br_st", 1'b1, 1'b1, 32'h1100);
    exec(32'h1040, OpcBeq, 1'b0, 1'b1, 1'b0, 32'h0);
    lookup(32'h1040);
    check_pred("br_wt", 1'b1, 1'b1, 32'h1100);
    exec(32'h1040, OpcBeq, 1'b0, 1'b1, 1'b0, 32'h0);
    exec(32'h1040, OpcBeq, 1'b0, 1'b1, 1'b0, 32'h0);
    lookup(32'h1040);
    check_pred("br_snt", 1'b1, 1'b0, 32'h1100);
    // Saturated at 0: one more not-taken then one taken leaves it at 1
    exec(32'h1040, OpcBeq, 1'b0, 1'b1, 1'b0, 32'h0);
    exec(32'h1040, OpcBeq, 1'b0, 1'b1, 1'b1, 32'h0);
    lookup(32'h1040);
    check_pred("br_sat0", 1'b1, 1'b0, 32'h1100);
    exec(32'h1040, OpcBeq, 1'b0, 1'b1, 1'b1, 32'h0);
    lookup(32'h1040);
    check_pred("br_wt2", 1'b1, 1'b1, 32'h1100);
    // Unconditional executes must not touch the counter (stays at 2)
    exec(32'h1040, OpcJalr, 1'b0, 1'b1, 1'b0, 32'h0);
    exec(32'h1040, OpcJalr, 1'b0, 1'b1, 1'b0, 32'h0);
    lookup(32'h1040);
    check_pred("br_uncond", 1'b1, 1'b1, 32'h1100);

    // 0x1040 = 0x1000 + 4*16 shares BTB index 0
    exec(32'h1000, OpcJal, 1'b1, 1'b1, 1'b1, 32'h2000);
    exec(32'h1040, OpcJal, 1'b1, 1'b1, 1'b1, 32'h3000);
    lookup(32'h1000);
    check_pred("alias_old", 1'b0, 1'b0, 32'h0);
    lookup(32'h1040);
    check_pred("alias_new", 1'b1, 1'b1, 32'h3000);

    // Same-cycle lookup and update; odd target kept; fresh counter 1 predicts not-taken
    idle();
    bus_if.fetch_req      = 1'b1;
    bus_if.fetch_pc       = 32'h1080;
    bus_if.update         = 1'b1;
    bus_if.opc            = OpcBne;
    bus_if.execute_pc     = 32'h1080;
    bus_if.execute_target = 32'h1235;
    tick();
    idle();
    check_pred("rbw_same", 1'b0, 1'b0, 32'h0);
    lookup(32'h1080);
    check_pred("rbw_next", 1'b1, 1'b0, 32'h1235);

    // Reset while a hitting lookup and an update are both in flight
    idle();
    rst                   = 1'b1;
    bus_if.fetch_req      = 1'b1;
    bus_if.fetch_pc       = 32'h1080;
    bus_if.update         = 1'b1;
    bus_if.opc            = OpcJal;
    bus_if.execute_pc     = 32'h1140;
    bus_if.execute_target = 32'h5000;
    tick();
    idle();
    rst = 1'b0;
    check_eq("rstmid_valid", 32'(bus_if.predict_valid), 32'd0);
    check_eq("rstmid_target", bus_if.predict_target, 32'd0);
    lookup(32'h1140);
    check_pred("rstmid_upd", 1'b0, 1'b0, 32'h0);
    lookup(32'h1080);
    check_pred("rstmid_btb", 1'b0, 1'b0, 32'h0);

    // Alternating T/N on 0x1100, 16 executes from a clean BHT
    exec(32'h1100, OpcBeq, 1'b1, 1'b0, 1'b0, 32'h1200);
    miss      = 0;
    late_miss = 0;
    for (int k = 0; k < 16; k++) begin
      lookup(32'h1100);
      pred   = bus_if.predict_taken;
      actual = (k % 2 == 0);
      if (pred != actual) begin
        miss++;
        if (k >= 8) late_miss++;
      end
      exec(32'h1100, OpcBeq, 1'b0, 1'b1, actual, 32'h0);
    end
`ifdef BPU_GSHARE_EN
    check_eq("alt_late_miss", 32'(late_miss), 32'd0);
`else
    check_eq("alt_miss", 32'(miss), 32'd16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
